// File: rtl/wg_slot_id_sched_pkg.sv
// wg_slot_id_sched_pkg: shared widths, occupancy constants and FSM encoding for the slot-id sequencer.
package wg_slot_id_sched_pkg;
  localparam int WG_ID_WIDTH      = 6;
  localparam int WG_SLOT_ID_WIDTH = 3;
  localparam int SLOT_ID_NUM      = 1 << WG_SLOT_ID_WIDTH;
  localparam int OCC_WIDTH        = WG_SLOT_ID_WIDTH + 1;
  localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(SLOT_ID_NUM);
  localparam logic [OCC_WIDTH-1:0] OCC_ONE  = OCC_WIDTH'(1);
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GEN     = 3'd1,
    ST_GEN_CAP = 3'd2,
    ST_FIND    = 3'd3,
    ST_CANCEL  = 3'd4
  } sched_st_e;
endpackage

// File: rtl/wg_slot_id_sched_rr_arb2.sv
// wg_slot_id_sched_rr_arb2: two-way round-robin grant with a single priority flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req[1:0] : request vector (bit 0 = release, bit 1 = allocate)
//   o_grant    : one-hot grant, combinational from i_req and the priority flop
module wg_slot_id_sched_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);
  // r_prio = 0 favours bit 0, 1 favours bit 1; it only matters when both request
  logic r_prio;
  assign o_grant = &i_req ? (r_prio ? 2'b10 : 2'b01) : i_req;
  // the loser of any grant becomes the favoured requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prio <= 1'b0;
    else if (|o_grant) r_prio <= o_grant[0];
  end
endmodule

// File: rtl/wg_slot_id_sched.sv
// wg_slot_id_sched: serialises workgroup slot allocate/release requests onto the slot-id converter.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   alloc_valid_i/_ready_o/_wg_id_i/_cu_id_i       : allocate request handshake
//   dealloc_valid_i/_ready_o/_wg_id_i/_cu_id_i     : release request handshake
//   alloc_rsp_valid_o/_ok_o/_slot_o                : one-cycle allocate response
//   dealloc_rsp_valid_o/_ok_o/_slot_o              : one-cycle release response
//   cu_full_o                       : per-CU "all slots in use"
//   conv_*_o / conv_slot_*_i        : converter control and returned slot ids
module wg_slot_id_sched
  import wg_slot_id_sched_pkg::*;
#(
  parameter int NUMBER_CU   = 2,
  parameter int CU_ID_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  input  logic [WG_ID_WIDTH-1:0]      alloc_wg_id_i,
  input  logic [CU_ID_WIDTH-1:0]      alloc_cu_id_i,
  input  logic                        dealloc_valid_i,
  output logic                        dealloc_ready_o,
  input  logic [WG_ID_WIDTH-1:0]      dealloc_wg_id_i,
  input  logic [CU_ID_WIDTH-1:0]      dealloc_cu_id_i,
  output logic                        alloc_rsp_valid_o,
  output logic                        alloc_rsp_ok_o,
  output logic [WG_SLOT_ID_WIDTH-1:0] alloc_rsp_slot_o,
  output logic                        dealloc_rsp_valid_o,
  output logic                        dealloc_rsp_ok_o,
  output logic [WG_SLOT_ID_WIDTH-1:0] dealloc_rsp_slot_o,
  output logic [NUMBER_CU-1:0]        cu_full_o,
  output logic [WG_ID_WIDTH-1:0]      conv_wg_id_o,
  output logic [CU_ID_WIDTH-1:0]      conv_cu_id_o,
  output logic                        conv_generate_o,
  output logic                        conv_find_and_cancel_o,
  input  logic [WG_SLOT_ID_WIDTH-1:0] conv_slot_gen_i,
  input  logic [WG_SLOT_ID_WIDTH-1:0] conv_slot_find_i
);
  sched_st_e                   r_state, w_next;
  logic [OCC_WIDTH-1:0]        r_occ [NUMBER_CU];
  logic [WG_ID_WIDTH-1:0]      r_wg_id;
  logic [CU_ID_WIDTH-1:0]      r_cu_id;
  logic                        r_ok;
  logic                        r_alloc_rsp_valid, r_alloc_rsp_ok;
  logic                        r_dealloc_rsp_valid, r_dealloc_rsp_ok;
  logic [WG_SLOT_ID_WIDTH-1:0] r_alloc_rsp_slot, r_dealloc_rsp_slot;
  logic [1:0]                  w_grant;
  logic                        w_cu_ok, w_has_room;

  // requests are only offered to the arbiter while idle, so a grant is a handshake
  wg_slot_id_sched_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   ({alloc_valid_i, dealloc_valid_i} & {2{r_state == ST_IDLE}}),
    .o_grant (w_grant)
  );

  assign w_cu_ok    = 32'(r_cu_id) < NUMBER_CU;
  assign w_has_room = r_occ[r_cu_id] != OCC_FULL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = w_grant[1] ? ST_GEN : (w_grant[0] ? ST_FIND : ST_IDLE);
      ST_GEN:  w_next = ST_GEN_CAP;
      ST_FIND: w_next = ST_CANCEL;
      default: w_next = ST_IDLE;
    endcase
  end

  // generate only exists in GEN, so it can never coincide with the cancel cycle
  always_comb begin
    alloc_ready_o          = w_grant[1];
    dealloc_ready_o        = w_grant[0];
    conv_generate_o        = (r_state == ST_GEN) && w_cu_ok && w_has_room;
    conv_find_and_cancel_o = (r_state == ST_FIND) && w_cu_ok;
  end

  // r_ok remembers whether the converter was actually driven for this request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wg_id             <= '0;
      r_cu_id             <= '0;
      r_ok                <= 1'b0;
      r_alloc_rsp_valid   <= 1'b0;
      r_alloc_rsp_ok      <= 1'b0;
      r_alloc_rsp_slot    <= '0;
      r_dealloc_rsp_valid <= 1'b0;
      r_dealloc_rsp_ok    <= 1'b0;
      r_dealloc_rsp_slot  <= '0;
      for (int i = 0; i < NUMBER_CU; i++) r_occ[i] <= '0;
    end else begin
      r_alloc_rsp_valid   <= r_state == ST_GEN_CAP;
      r_dealloc_rsp_valid <= r_state == ST_CANCEL;
      if (|w_grant) begin
        r_wg_id <= w_grant[1] ? alloc_wg_id_i : dealloc_wg_id_i;
        r_cu_id <= w_grant[1] ? alloc_cu_id_i : dealloc_cu_id_i;
      end
      if (r_state == ST_GEN) r_ok <= conv_generate_o;
      if (r_state == ST_FIND) r_ok <= conv_find_and_cancel_o;
      if (conv_generate_o) r_occ[r_cu_id] <= r_occ[r_cu_id] + OCC_ONE;
      if (r_state == ST_GEN_CAP) begin
        r_alloc_rsp_ok   <= r_ok;
        r_alloc_rsp_slot <= r_ok ? conv_slot_gen_i : '0;
      end
      if (r_state == ST_CANCEL) begin
        r_dealloc_rsp_ok   <= r_ok;
        r_dealloc_rsp_slot <= r_ok ? conv_slot_find_i : '0;
        if (r_ok && r_occ[r_cu_id] != '0) r_occ[r_cu_id] <= r_occ[r_cu_id] - OCC_ONE;
      end
    end
  end

  for (genvar c = 0; c < NUMBER_CU; c++) begin : g_full
    assign cu_full_o[c] = r_occ[c] == OCC_FULL;
  end

  assign conv_wg_id_o        = r_wg_id;
  assign conv_cu_id_o        = r_cu_id;
  assign alloc_rsp_valid_o   = r_alloc_rsp_valid;
  assign alloc_rsp_ok_o      = r_alloc_rsp_ok;
  assign alloc_rsp_slot_o    = r_alloc_rsp_slot;
  assign dealloc_rsp_valid_o = r_dealloc_rsp_valid;
  assign dealloc_rsp_ok_o    = r_dealloc_rsp_ok;
  assign dealloc_rsp_slot_o  = r_dealloc_rsp_slot;
endmodule

// File: tb/tb_wg_slot_id_sched.sv
// tb_wg_slot_id_sched: scoreboard bench for the slot-id sequencer with a behavioural converter.
module tb_wg_slot_id_sched;
  import wg_slot_id_sched_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       alloc_valid_i = 1'b0, dealloc_valid_i = 1'b0;
  logic       alloc_ready_o, dealloc_ready_o;
  logic [5:0] alloc_wg_id_i = '0, dealloc_wg_id_i = '0;
  logic       alloc_cu_id_i = 1'b0, dealloc_cu_id_i = 1'b0;
  logic       alloc_rsp_valid_o, alloc_rsp_ok_o, dealloc_rsp_valid_o, dealloc_rsp_ok_o;
  logic [2:0] alloc_rsp_slot_o, dealloc_rsp_slot_o;
  logic [1:0] cu_full_o;
  logic [5:0] conv_wg_id_o;
  logic       conv_cu_id_o, conv_generate_o, conv_find_and_cancel_o;
  logic [2:0] conv_slot_gen_i, conv_slot_find_i;

  always #5 clk = ~clk;

  wg_slot_id_sched #(.NUMBER_CU(2), .CU_ID_WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_wg_id_i(alloc_wg_id_i), .alloc_cu_id_i(alloc_cu_id_i),
    .dealloc_valid_i(dealloc_valid_i), .dealloc_ready_o(dealloc_ready_o),
    .dealloc_wg_id_i(dealloc_wg_id_i), .dealloc_cu_id_i(dealloc_cu_id_i),
    .alloc_rsp_valid_o(alloc_rsp_valid_o), .alloc_rsp_ok_o(alloc_rsp_ok_o),
    .alloc_rsp_slot_o(alloc_rsp_slot_o),
    .dealloc_rsp_valid_o(dealloc_rsp_valid_o), .dealloc_rsp_ok_o(dealloc_rsp_ok_o),
    .dealloc_rsp_slot_o(dealloc_rsp_slot_o),
    .cu_full_o(cu_full_o),
    .conv_wg_id_o(conv_wg_id_o), .conv_cu_id_o(conv_cu_id_o),
    .conv_generate_o(conv_generate_o), .conv_find_and_cancel_o(conv_find_and_cancel_o),
    .conv_slot_gen_i(conv_slot_gen_i), .conv_slot_find_i(conv_slot_find_i)
  );

  // behavioural converter: lowest free slot on generate, CAM lookup and free on find
  logic       m_used [2][8];
  logic [5:0] m_wg   [2][8];
  logic [2:0] m_free;
  logic [3:0] m_hit;

  function automatic logic [2:0] lowest_free(input logic cu);
    logic [2:0] r = '0;
    for (int s = 7; s >= 0; s--) if (!m_used[cu][s]) r = 3'(s);
    return r;
  endfunction

  function automatic logic [3:0] find_wg(input logic cu, input logic [5:0] wg);
    logic [3:0] r = '0;
    for (int s = 0; s < 8; s++) if (m_used[cu][s] && m_wg[cu][s] == wg) r = {1'b1, 3'(s)};
    return r;
  endfunction

  always_comb begin
    m_free = lowest_free(conv_cu_id_o);
    m_hit  = find_wg(conv_cu_id_o, conv_wg_id_o);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) for (int s = 0; s < 8; s++) m_used[c][s] <= 1'b0;
      conv_slot_gen_i  <= '0;
      conv_slot_find_i <= '0;
    end else begin
      if (conv_generate_o) begin
        conv_slot_gen_i                <= m_free;
        m_used[conv_cu_id_o][m_free]   <= 1'b1;
        m_wg[conv_cu_id_o][m_free]     <= conv_wg_id_o;
      end
      if (conv_find_and_cancel_o) begin
        conv_slot_find_i <= m_hit[2:0];
        if (m_hit[3]) m_used[conv_cu_id_o][m_hit[2:0]] <= 1'b0;
      end
    end
  end

  typedef struct {bit is_alloc; bit ok; logic [2:0] slot; int due;} exp_t;
  typedef struct {bit got; bit ok; logic [2:0] slot; int lat; int gen_cyc; int find_cyc;
                  logic [5:0] wg1; logic cu1; logic [5:0] wg2; logic gen2;} obs_t;
  exp_t sbq[$];
  int n_tests = 0, n_fail = 0;

  task automatic do_reset();
    rst_n = 1'b0; alloc_valid_i = 1'b0; dealloc_valid_i = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // one request in isolation: expected response pushed at handshake, observations returned
  task automatic send(input bit is_alloc, input logic [5:0] wg, input logic cu,
                      input bit eok, input logic [2:0] eslot, output obs_t o);
    exp_t e;
    int k = 0;
    o = '{got: 0, ok: 0, slot: 0, lat: -1, gen_cyc: -1, find_cyc: -1, wg1: 0, cu1: 0, wg2: 0, gen2: 0};
    @(negedge clk);
    if (is_alloc) begin alloc_valid_i = 1'b1; alloc_wg_id_i = wg; alloc_cu_id_i = cu; end
    else begin dealloc_valid_i = 1'b1; dealloc_wg_id_i = wg; dealloc_cu_id_i = cu; end
    #1;
    while (!(is_alloc ? alloc_ready_o : dealloc_ready_o) && k < 10) begin @(negedge clk); #1; k++; end
    e.is_alloc = is_alloc; e.ok = eok; e.slot = eslot; e.due = 3;
    sbq.push_back(e);
    @(posedge clk); #1;
    alloc_valid_i = 1'b0; dealloc_valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (conv_generate_o && o.gen_cyc < 0) begin o.gen_cyc = c; o.wg1 = conv_wg_id_o; o.cu1 = conv_cu_id_o; end
      if (conv_find_and_cancel_o && o.find_cyc < 0) begin o.find_cyc = c; o.wg1 = conv_wg_id_o; o.cu1 = conv_cu_id_o; end
      if (c == 2) begin o.wg2 = conv_wg_id_o; o.gen2 = conv_generate_o; end
      if ((is_alloc ? alloc_rsp_valid_o : dealloc_rsp_valid_o) && !o.got) begin
        o.got = 1; o.lat = c;
        o.ok = is_alloc ? alloc_rsp_ok_o : dealloc_rsp_ok_o;
        o.slot = is_alloc ? alloc_rsp_slot_o : dealloc_rsp_slot_o;
      end
    end
  endtask

  // both requesters active together; responses popped from the scoreboard as they appear
  task automatic run_pair(input logic [5:0] a_wg, input logic a_cu, input bit a_ok, input logic [2:0] a_slot,
                          input logic [5:0] d_wg, input logic d_cu, input bit d_ok, input logic [2:0] d_slot,
                          input int n, output logic [3:0] order, output int span);
    exp_t e;
    int g = 0, first = -1, last = -1;
    bit bad = 0, prev_find = 0, r_ok;
    logic [2:0] r_slot;
    order = '0;
    alloc_valid_i = 1'b1; alloc_wg_id_i = a_wg; alloc_cu_id_i = a_cu;
    dealloc_valid_i = 1'b1; dealloc_wg_id_i = d_wg; dealloc_cu_id_i = d_cu;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (conv_generate_o && (conv_find_and_cancel_o || prev_find)) bad = 1;
      prev_find = conv_find_and_cancel_o;
      if (alloc_rsp_valid_o || dealloc_rsp_valid_o) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL pair_rsp: response at cycle %0d, expected none", c);
        end else begin
          e = sbq.pop_front();
          r_ok = e.is_alloc ? alloc_rsp_ok_o : dealloc_rsp_ok_o;
          r_slot = e.is_alloc ? alloc_rsp_slot_o : dealloc_rsp_slot_o;
          if (alloc_rsp_valid_o !== e.is_alloc || r_ok !== e.ok || r_slot !== e.slot || c !== e.due) begin
            n_fail++;
            $display("FAIL pair_rsp: got alloc=%0b ok=%0b slot=%0d cycle=%0d, expected alloc=%0b ok=%0b slot=%0d cycle=%0d",
                     alloc_rsp_valid_o, r_ok, r_slot, c, e.is_alloc, e.ok, e.slot, e.due);
          end
        end
      end
      if (g < n && (alloc_ready_o || dealloc_ready_o)) begin
        e.is_alloc = alloc_ready_o; e.due = c + 3;
        e.ok = alloc_ready_o ? a_ok : d_ok;
        e.slot = alloc_ready_o ? a_slot : d_slot;
        sbq.push_back(e);
        order[g] = alloc_ready_o;
        if (first < 0) first = c;
        last = c;
        g++;
        if (g == n) begin @(posedge clk); #1; alloc_valid_i = 1'b0; dealloc_valid_i = 1'b0; end
      end
      if (g == n && sbq.size() == 0) break;
      @(negedge clk); #1;
    end
    span = last - first;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL pair_ctrl: generate overlapped find or cancel cycle, expected never"); end
    n_tests++;
    if (g != n || sbq.size() != 0) begin
      n_fail++;
      $display("FAIL pair_done: grants=%0d pending=%0d, expected grants=%0d pending=0", g, sbq.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alloc_valid_i = 1'b0; dealloc_valid_i = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({alloc_ready_o, dealloc_ready_o, alloc_rsp_valid_o, alloc_rsp_ok_o, alloc_rsp_slot_o,
         dealloc_rsp_valid_o, dealloc_rsp_ok_o, dealloc_rsp_slot_o, cu_full_o, conv_wg_id_o,
         conv_cu_id_o, conv_generate_o, conv_find_and_cancel_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gen=%0b find=%0b wg=%0d full=%b arsp=%0b drsp=%0b, expected all 0",
               conv_generate_o, conv_find_and_cancel_o, conv_wg_id_o, cu_full_o, alloc_rsp_valid_o, dealloc_rsp_valid_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alloc_basic();
    obs_t o; exp_t e;
    send(1, 6'd5, 1'b1, 1, 3'd0, o);
    e = sbq.pop_front();
    n_tests++;
    if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due) begin
      n_fail++;
      $display("FAIL basic_rsp: got ok=%0b slot=%0d lat=%0d, expected ok=%0b slot=%0d lat=%0d", o.ok, o.slot, o.lat, e.ok, e.slot, e.due);
    end
    n_tests++;
    if (o.gen_cyc !== 1 || o.wg1 !== 6'd5 || o.cu1 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_gen: got cycle=%0d wg=%0d cu=%0d, expected cycle=1 wg=5 cu=1", o.gen_cyc, o.wg1, o.cu1);
    end
    n_tests++;
    if (cu_full_o !== 2'b00) begin n_fail++; $display("FAIL basic_full: got %b, expected 00", cu_full_o); end
  endtask

  task automatic test_full();
    obs_t o; exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(1, 6'(10 + i), 1'b0, 1, 3'(i), o);
      e = sbq.pop_front();
      n_tests++;
      if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due) begin
        n_fail++;
        $display("FAIL fill_%0d: got ok=%0b slot=%0d lat=%0d, expected ok=%0b slot=%0d lat=%0d", i, o.ok, o.slot, o.lat, e.ok, e.slot, e.due);
      end
    end
    n_tests++;
    if (cu_full_o !== 2'b01) begin n_fail++; $display("FAIL fill_full: got %b, expected 01", cu_full_o); end
    send(1, 6'd30, 1'b0, 0, 3'd0, o);
    e = sbq.pop_front();
    n_tests++;
    if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due || o.gen_cyc !== -1) begin
      n_fail++;
      $display("FAIL overfill: got ok=%0b slot=%0d lat=%0d gen_cycle=%0d, expected ok=0 slot=0 lat=3 gen_cycle=-1",
               o.ok, o.slot, o.lat, o.gen_cyc);
    end
  endtask

  task automatic test_release_pending();
    logic [3:0] order; int span;
    run_pair(6'd20, 1'b0, 1, 3'd3, 6'd13, 1'b0, 1, 3'd3, 2, order, span);
    n_tests++;
    if (order[1:0] !== 2'b10 || span !== 3) begin
      n_fail++;
      $display("FAIL pending_order: got order=%b span=%0d, expected order=10 span=3", order[1:0], span);
    end
    n_tests++;
    if (cu_full_o !== 2'b01) begin n_fail++; $display("FAIL pending_full: got %b, expected 01", cu_full_o); end
  endtask

  task automatic test_find();
    obs_t o; exp_t e;
    do_reset();
    send(1, 6'd3, 1'b0, 1, 3'd0, o);
    e = sbq.pop_front();
    n_tests++;
    if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due) begin
      n_fail++; $display("FAIL find_a3: got ok=%0b slot=%0d lat=%0d, expected ok=1 slot=0 lat=3", o.ok, o.slot, o.lat);
    end
    send(1, 6'd9, 1'b0, 1, 3'd1, o);
    e = sbq.pop_front();
    n_tests++;
    if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due) begin
      n_fail++; $display("FAIL find_a9: got ok=%0b slot=%0d lat=%0d, expected ok=1 slot=1 lat=3", o.ok, o.slot, o.lat);
    end
    send(0, 6'd9, 1'b0, 1, 3'd1, o);
    e = sbq.pop_front();
    n_tests++;
    if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due) begin
      n_fail++; $display("FAIL find_rsp: got ok=%0b slot=%0d lat=%0d, expected ok=1 slot=1 lat=3", o.ok, o.slot, o.lat);
    end
    n_tests++;
    if (o.find_cyc !== 1 || o.wg1 !== 6'd9 || o.wg2 !== 6'd9 || o.gen2 !== 1'b0) begin
      n_fail++;
      $display("FAIL find_ctrl: got find_cycle=%0d wg1=%0d wg2=%0d gen2=%0b, expected find_cycle=1 wg1=9 wg2=9 gen2=0",
               o.find_cyc, o.wg1, o.wg2, o.gen2);
    end
    send(1, 6'd4, 1'b0, 1, 3'd1, o);
    e = sbq.pop_front();
    n_tests++;
    if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due) begin
      n_fail++; $display("FAIL find_realloc: got ok=%0b slot=%0d lat=%0d, expected ok=1 slot=1 lat=3", o.ok, o.slot, o.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] order; int span;
    rst_n = 1'b0; sbq.delete();
    alloc_valid_i = 1'b1; alloc_wg_id_i = 6'd7; alloc_cu_id_i = 1'b1;
    dealloc_valid_i = 1'b1; dealloc_wg_id_i = 6'd7; dealloc_cu_id_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_pair(6'd7, 1'b1, 1, 3'd0, 6'd7, 1'b1, 1, 3'd0, 3, order, span);
    n_tests++;
    if (order[2:0] !== 3'b010 || span !== 6) begin
      n_fail++;
      $display("FAIL b2b_order: got order=%b span=%0d, expected order=010 span=6", order[2:0], span);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    bit seen = 0;
    do_reset();
    alloc_valid_i = 1'b1; alloc_wg_id_i = 6'd2; alloc_cu_id_i = 1'b0;
    #1;
    n_tests++;
    if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b, expected 1", alloc_ready_o); end
    @(posedge clk); #1;
    alloc_valid_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (conv_generate_o !== 1'b1) begin n_fail++; $display("FAIL mid_gen: got %0b, expected 1", conv_generate_o); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({alloc_ready_o, dealloc_ready_o, alloc_rsp_valid_o, dealloc_rsp_valid_o, cu_full_o, conv_wg_id_o,
         conv_generate_o, conv_find_and_cancel_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got gen=%0b wg=%0d full=%b, expected all 0", conv_generate_o, conv_wg_id_o, cu_full_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (alloc_rsp_valid_o) seen = 1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL mid_norsp: got a response after reset, expected none"); end
    send(1, 6'd2, 1'b0, 1, 3'd0, o);
    e = sbq.pop_front();
    n_tests++;
    if (o.ok !== e.ok || o.slot !== e.slot || o.lat !== e.due) begin
      n_fail++; $display("FAIL mid_realloc: got ok=%0b slot=%0d lat=%0d, expected ok=1 slot=0 lat=3", o.ok, o.slot, o.lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alloc_basic();
    test_full();
    test_release_pending();
    test_find();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
